// File: rtl/pb_conditioner.sv
// Push-button conditioner: per button, a two-flop synchroniser, a counter
// debounce, one-cycle press/release pulses and an auto-repeat strobe while
// the button is held. Every bit is an independent copy of the same slice.
//
// Handshake note: there is no valid/ready traffic here. Outputs are plain
// registered levels and single-cycle pulses, so a consumer simply samples
// them every clock.
//
// The release pulse port is named release_o because "release" is a reserved
// word in SystemVerilog.
module pb_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] strobe
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Per-button auto-repeat state, gathered in one vector for observation.
    logic [N_BTN-1:0][1:0] rpt_state_dbg;

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pb;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
        logic              level_q, level_d;
        logic              press_q, release_q, strobe_q;
        logic              rise, fall;
        rpt_state_e        state_q, state_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              rpt_fire;

        // Debounce: count consecutive disagreeing cycles, flip level on the last one.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            rise     = 1'b0;
            fall     = 1'b0;
            if (s2_q[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_d = '0;
                level_d  = s2_q[i];
                rise     = s2_q[i];
                fall     = ~s2_q[i];
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end

        // Auto-repeat next state; a release always wins over a due repeat.
        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            rpt_fire = 1'b0;
            if (fall) begin
                state_d = RPT_IDLE;
                hold_d  = '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (rise && (REPEAT_DELAY != 0)) begin
                            state_d = RPT_DELAY;
                            hold_d  = HOLD_ONE;
                        end
                    end
                    RPT_DELAY: begin
                        if (hold_q == DELAY_LAST) begin
                            rpt_fire = 1'b1;
                            state_d  = RPT_REPEAT;
                            hold_d   = HOLD_ONE;
                        end else begin
                            hold_d = hold_q + HOLD_ONE;
                        end
                    end
                    RPT_REPEAT: begin
                        if (hold_q == PERIOD_LAST) begin
                            rpt_fire = 1'b1;
                            hold_d   = HOLD_ONE;
                        end else begin
                            hold_d = hold_q + HOLD_ONE;
                        end
                    end
                    default: begin
                        state_d = RPT_IDLE;
                        hold_d  = '0;
                    end
                endcase
            end
        end

        // State and registered pulse outputs for this button.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                strobe_q  <= 1'b0;
                state_q   <= RPT_IDLE;
                hold_q    <= '0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= rise;
                release_q <= fall;
                strobe_q  <= rise | rpt_fire;
                state_q   <= state_d;
                hold_q    <= hold_d;
            end
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_o[i]     = release_q;
        assign strobe[i]        = strobe_q;
        assign rpt_state_dbg[i] = state_q;
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, plus a second instance with auto-repeat disabled.
// Timing convention: inputs change 1 time unit after posedge number c
// ("edge 0"); a debounced change is then visible after posedge c+6.
module tb_pb_conditioner;

  localparam int NB = 5;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NB-1:0] pb = '0;
  logic [NB-1:0] pb_nr = '0;
  logic [NB-1:0] level, press, rel, strobe;
  logic [NB-1:0] level_nr, press_nr, rel_nr, strobe_nr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  pb_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pb(pb),
    .level(level), .press(press), .release_o(rel), .strobe(strobe)
  );

  pb_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
  ) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .pb(pb_nr),
    .level(level_nr), .press(press_nr), .release_o(rel_nr), .strobe(strobe_nr)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got=timeout want=finish");
    $fatal(1);
  end

  // event encoding: cycle, kind (0 press, 1 release, 2 strobe), button
  function automatic logic [31:0] ev(input int c, input int kind, input int b);
    logic [25:0] cc;
    logic [2:0] kk;
    logic [2:0] bb;
    cc = c[25:0];
    kk = kind[2:0];
    bb = b[2:0];
    return {cc, kk, bb};
  endfunction

  // monitor: log every pulse of the main instance
  always @(posedge clk) begin
    #2;
    if (mon_en && rst_n) begin
      for (int b = 0; b < NB; b++) begin
        if (press[b]) obs_q.push_back(ev(cyc, 0, b));
        if (rel[b]) obs_q.push_back(ev(cyc, 1, b));
        if (strobe[b]) obs_q.push_back(ev(cyc, 2, b));
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk5(input string name, input logic [NB-1:0] act, input logic [NB-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, act, want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic push_ev(input int c, input int kind, input int b);
    exp_q.push_back(ev(c, kind, b));
  endtask

  // scoreboard: every expected event must be observed, nothing extra
  task automatic sb_check(input string name);
    logic [31:0] e;
    int idx;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idx = -1;
      for (int k = 0; k < obs_q.size(); k++) begin
        if (obs_q[k] == e) begin
          idx = k;
          break;
        end
      end
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL %s missing event cyc=%0d kind=%0d btn=%0d got=absent want=present",
                 name, e[31:6], e[5:3], e[2:0]);
      end else begin
        obs_q.delete(idx);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      e = obs_q[0];
      $display("FAIL %s unexpected events got=%0d want=0 first cyc=%0d kind=%0d btn=%0d",
               name, obs_q.size(), e[31:6], e[5:3], e[2:0]);
    end
    obs_q.delete();
  endtask

  typedef struct {
    logic [NB-1:0] pb_in;
    int            adv;
    logic [NB-1:0] e_level;
    logic [NB-1:0] e_press;
    logic [NB-1:0] e_rel;
    logic [NB-1:0] e_strobe;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int c;
    int n_s;
    int n_p;
    int s_cyc;
    int p_cyc;

    // clean press, repeats, release on a repeat boundary (drive at edge 0)
    tbl[0]  = '{5'b00001, 5, 5'b00000, 5'b00000, 5'b00000, 5'b00000}; // +5
    tbl[1]  = '{5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00001}; // +6 press
    tbl[2]  = '{5'b00001, 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000}; // +7
    tbl[3]  = '{5'b00001, 9, 5'b00001, 5'b00000, 5'b00000, 5'b00001}; // +16 first repeat
    tbl[4]  = '{5'b00001, 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000}; // +17
    tbl[5]  = '{5'b00001, 2, 5'b00001, 5'b00000, 5'b00000, 5'b00001}; // +19
    tbl[6]  = '{5'b00001, 3, 5'b00001, 5'b00000, 5'b00000, 5'b00001}; // +22
    tbl[7]  = '{5'b00001, 3, 5'b00001, 5'b00000, 5'b00000, 5'b00001}; // +25
    tbl[8]  = '{5'b00000, 3, 5'b00001, 5'b00000, 5'b00000, 5'b00001}; // drop @+25, +28 repeat
    tbl[9]  = '{5'b00000, 2, 5'b00001, 5'b00000, 5'b00000, 5'b00000}; // +30
    tbl[10] = '{5'b00000, 1, 5'b00000, 5'b00000, 5'b00001, 5'b00000}; // +31 release, repeat suppressed
    tbl[11] = '{5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000}; // +32
    tbl[12] = '{5'b00000, 10, 5'b00000, 5'b00000, 5'b00000, 5'b00000}; // +42

    // reset
    #2 rst_n = 1'b0;
    wait_edges(3);
    chk5("rst_level", level, '0);
    chk5("rst_press", press, '0);
    chk5("rst_release", rel, '0);
    chk5("rst_strobe", strobe, '0);
    chk5("rst_nr_all", level_nr | press_nr | rel_nr | strobe_nr, '0);
    rst_n = 1'b1;
    wait_edges(2);

    // table-driven clean press / release
    for (int i = 0; i < 13; i++) begin
      pb = tbl[i].pb_in;
      wait_edges(tbl[i].adv);
      chk5($sformatf("vec%0d_level", i), level, tbl[i].e_level);
      chk5($sformatf("vec%0d_press", i), press, tbl[i].e_press);
      chk5($sformatf("vec%0d_release", i), rel, tbl[i].e_rel);
      chk5($sformatf("vec%0d_strobe", i), strobe, tbl[i].e_strobe);
    end

    // bounce rejection on bit 1
    obs_q.delete();
    mon_en = 1'b1;
    pb[1] = 1'b1; wait_edges(2);
    pb[1] = 1'b0; wait_edges(2);
    pb[1] = 1'b1; wait_edges(2);
    pb[1] = 1'b0; wait_edges(2);
    pb[1] = 1'b1;
    c = cyc;
    push_ev(c + 6, 0, 1);
    push_ev(c + 6, 2, 1);
    push_ev(c + 6 + RD, 2, 1);
    wait_edges(12);
    pb[1] = 1'b0;
    push_ev(c + 18, 1, 1);
    wait_edges(20);
    sb_check("bounce");

    // independence: bit 4 released on its first-repeat cycle, bit 2 keeps repeating
    pb[2] = 1'b1;
    pb[4] = 1'b1;
    c = cyc;
    push_ev(c + 6, 0, 2);
    push_ev(c + 6, 0, 4);
    push_ev(c + 6, 2, 2);
    push_ev(c + 6, 2, 4);
    wait_edges(10);
    pb[4] = 1'b0;
    push_ev(c + 16, 1, 4);
    push_ev(c + 16, 2, 2);
    push_ev(c + 19, 2, 2);
    push_ev(c + 22, 2, 2);
    push_ev(c + 25, 2, 2);
    wait_edges(10);
    pb[2] = 1'b0;
    push_ev(c + 26, 1, 2);
    wait_edges(20);
    sb_check("indep");

    // reset while bit 3 is in the repeat phase
    pb[3] = 1'b1;
    c = cyc;
    push_ev(c + 6, 0, 3);
    push_ev(c + 6, 2, 3);
    push_ev(c + 16, 2, 3);
    push_ev(c + 19, 2, 3);
    wait_edges(19);
    #2 rst_n = 1'b0;
    #1;
    chk5("rstmid_level", level, '0);
    chk5("rstmid_pulses", press | rel | strobe, '0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk5($sformatf("rstmid_hold%0d", k), level | press | rel | strobe, '0);
    end
    rst_n = 1'b1;
    c = cyc;
    push_ev(c + 6, 0, 3);
    push_ev(c + 6, 2, 3);
    wait_edges(5);
    chk5("rstmid_pre_level", level, '0);
    wait_edges(3);
    pb[3] = 1'b0;
    push_ev(c + 14, 1, 3);
    wait_edges(20);
    sb_check("reset_mid");
    mon_en = 1'b0;

    // repeat disabled instance: exactly one strobe, with the press
    pb_nr[0] = 1'b1;
    c = cyc;
    n_s = 0;
    n_p = 0;
    s_cyc = -1;
    p_cyc = -1;
    for (int k = 0; k < 50; k++) begin
      wait_edges(1);
      if (strobe_nr[0]) begin
        n_s++;
        s_cyc = cyc;
      end
      if (press_nr[0]) begin
        n_p++;
        p_cyc = cyc;
      end
    end
    chk_int("norpt_strobe_count", n_s, 1);
    chk_int("norpt_press_count", n_p, 1);
    chk_int("norpt_strobe_cycle", s_cyc, c + 6);
    chk_int("norpt_press_cycle", p_cyc, c + 6);
    chk5("norpt_level", level_nr, 5'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
